// File: rtl/debounce_filter_if.sv
// debounce_filter_if: sample-qualifier, raw input and filtered outputs
// of the debounce filter, bundled for port connection.
interface debounce_filter_if;
  logic en;
  logic d;
  logic q;
  logic busy;

  modport master (
    output en,
    output d,
    input  q,
    input  busy
  );

  modport slave (
    input  en,
    input  d,
    output q,
    output busy
  );
endinterface

// File: rtl/debounce_filter.sv
// debounce_filter: counter-based glitch filter, new level accepted after
// STABLE_CNT stable qualifying samples. DEBOUNCE_SYNC_EN adds 2-FF sync on d.
module debounce_filter #(
  parameter int   STABLE_CNT = 16,
  parameter int   CNT_W      = $clog2(STABLE_CNT + 1),
  parameter logic INIT       = 1'b0
) (
  input logic               clk,
  input logic               reset_n,
  debounce_filter_if.slave  bus
);

  if (STABLE_CNT < 1 || STABLE_CNT > 65535) begin : g_bad_cnt
    $error("debounce_filter: STABLE_CNT out of range 1..65535");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_q, sync2_q;

  // Synchronizer runs every clock so en gating does not stretch its delay
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= INIT;
      sync2_q <= INIT;
    end else begin
      sync1_q <= bus.d;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = bus.d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      q_q     <= INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (bus.en) begin
      priority case (1'b1)
        (s == q_q): begin
          cnt_d   = '0;
          state_d = STABLE;
        end
        (cnt_q == LAST): begin
          q_d     = s;
          cnt_d   = '0;
          state_d = STABLE;
        end
        default: begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = COUNT;
        end
      endcase
    end
  end

  // COUNT is held exactly while cnt is nonzero, so the state flop is busy
  assign bus.q    = q_q;
  assign bus.busy = (state_q == COUNT);

endmodule

// File: tb/tb_debounce_filter.sv
// tb_debounce_filter: three filter instances driven in parallel, checked
// against a sample-history reference model via a scoreboard queue.
module tb_debounce_filter;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic d = 1'b0;

  always #5 clk = ~clk;

  debounce_filter_if if0 ();
  debounce_filter_if if1 ();
  debounce_filter_if if2 ();

  assign if0.en = en;
  assign if0.d  = d;
  assign if1.en = en;
  assign if1.d  = d;
  assign if2.en = en;
  assign if2.d  = d;

  debounce_filter #(.STABLE_CNT(4), .INIT(1'b0)) u0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave));
  debounce_filter #(.STABLE_CNT(1), .INIT(1'b1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave));
  debounce_filter #(.STABLE_CNT(8), .INIT(1'b1)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(if2.slave));

  typedef struct packed {
    logic [ND-1:0] q;
    logic [ND-1:0] busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  int nval[ND] = '{4, 1, 8};
  bit ival[ND] = '{1'b0, 1'b1, 1'b1};
  bit mq[ND];
  bit s1[ND];
  bit s2[ND];
  bit hist[ND][$];

  // Model: q flips once the run of qualifying samples that
  // differ from q reaches STABLE_CNT; busy means the run is nonempty.
  function automatic void model_edge();
    exp_t x;
    bit   s;
    for (int i = 0; i < ND; i++) begin
      if (!reset_n) begin
        mq[i] = ival[i];
        s1[i] = ival[i];
        s2[i] = ival[i];
        hist[i].delete();
      end else begin
`ifdef DEBOUNCE_SYNC_EN
        s     = s2[i];
        s2[i] = s1[i];
        s1[i] = d;
`else
        s = d;
`endif
        if (en) begin
          if (s == mq[i]) begin
            hist[i].delete();
          end else begin
            hist[i].push_back(s);
            if (hist[i].size() >= nval[i]) begin
              mq[i] = s;
              hist[i].delete();
            end
          end
        end
      end
      x.q[i]    = mq[i];
      x.busy[i] = (hist[i].size() != 0);
    end
    sb.push_back(x);
  endfunction

  task automatic step(input bit r, input bit e, input bit dv);
    @(negedge clk);
    reset_n = r;
    en      = e;
    d       = dv;
    @(posedge clk);
    model_edge();
  endtask

  task automatic hold(input bit dv, input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, dv);
  endtask

  function automatic void chk(input string nm, input int i,
                              input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%b required=%b",
               nm, i, $time, a, e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t x;
    logic [ND-1:0] aq;
    logic [ND-1:0] ab;
    if (sb.size() != 0) begin
      x  = sb.pop_front();
      aq = {if2.q, if1.q, if0.q};
      ab = {if2.busy, if1.busy, if0.busy};
      for (int i = 0; i < ND; i++) begin
        chk("q", i, aq[i], x.q[i]);
        chk("busy", i, ab[i], x.busy[i]);
      end
    end
  end

  initial begin
    bit dv;
    bit e;
    bit r;

    // reset with d high: outputs must show INIT, not d
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1);

    // settle low, then clean step
    hold(1'b0, 12);
    hold(1'b1, 14);

    // glitch rejection: 3-sample pulses, then a 4-sample one
    hold(1'b0, 14);
    hold(1'b1, 3);
    hold(1'b0, 6);
    hold(1'b1, 4);
    hold(1'b0, 14);

    // enable every 3rd clock with d stepped high
    for (int c = 0; c < 40; c++) step(1'b1, (c % 3) == 0, 1'b1);
    for (int c = 0; c < 40; c++) step(1'b1, (c % 3) == 0, 1'b0);

    // reset in the middle of a count
    hold(1'b0, 12);
    hold(1'b1, 5);
    step(1'b0, 1'b1, 1'b1);
    hold(1'b1, 14);

    // toggle every clock
    for (int c = 0; c < 24; c++) step(1'b1, 1'b1, c[0]);

    // randomized phase
    dv = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) dv = ~dv;
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 299) != 0);
      step(r, e, dv);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
